// File: rtl/reg_file_rename_pkg.sv
// Shared constants and the read-response record for the renaming register file.
package reg_file_rename_pkg;

    localparam int REG_ADDR_WIDTH    = 5;
    localparam int NUM_ARCH_REGS     = 32;
    localparam int DEFAULT_XLEN      = 32;
    localparam int DEFAULT_ROB_WIDTH = 3;

    // Response layout at the default widths.
    typedef struct packed {
        logic                         valid;
        logic                         busy;
        logic [DEFAULT_ROB_WIDTH-1:0] tag;
        logic [DEFAULT_XLEN-1:0]      data;
    } rd_rsp_t;

endpackage

// File: rtl/reg_file_read_port.sv
// Combinational operand lookup for one read port: x0 forcing and same-cycle commit bypass.
module reg_file_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int ROB_WIDTH = DEFAULT_ROB_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_addr,
    input  logic [XLEN-1:0]           i_reg_data,
    input  logic                      i_reg_busy,
    input  logic [ROB_WIDTH-1:0]      i_reg_tag,
    input  logic                      i_cm_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_cm_rd,
    input  logic [ROB_WIDTH-1:0]      i_cm_tag,
    input  logic [XLEN-1:0]           i_cm_data,
    output logic [XLEN-1:0]           o_data,
    output logic                      o_busy,
    output logic [ROB_WIDTH-1:0]      o_tag
);

    logic w_bypass;

    // Only the commit of the producer currently named in the rename table resolves the operand.
    assign w_bypass = i_cm_valid && (i_cm_rd == i_addr) && i_reg_busy && (i_cm_tag == i_reg_tag);

    always_comb begin
        o_data = i_reg_data;
        o_busy = i_reg_busy;
        o_tag  = i_reg_tag;
        if (i_addr == '0) begin
            o_data = '0;
            o_busy = 1'b0;
            o_tag  = '0;
        end else if (w_bypass) begin
            o_data = i_cm_data;
            o_busy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with rename table (busy + ROB tag), registered read ports and flush.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int NUM_READ  = 2,
    parameter int RS_WIDTH  = 2,
    parameter int ROB_WIDTH = DEFAULT_ROB_WIDTH
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic                                rdy_in,
    input  logic                                flush_in,
    input  logic [NUM_READ-1:0]                 rd_req_in,
    input  logic [NUM_READ*REG_ADDR_WIDTH-1:0]  rd_addr_in,
    input  logic [RS_WIDTH-1:0]                 rd_index_in,
    input  logic                                rn_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0]           rn_rd_in,
    input  logic [ROB_WIDTH-1:0]                rn_tag_in,
    input  logic                                cm_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0]           cm_rd_in,
    input  logic [ROB_WIDTH-1:0]                cm_tag_in,
    input  logic [XLEN-1:0]                     cm_data_in,
    output logic [NUM_READ-1:0]                 rd_valid_out,
    output logic [NUM_READ*XLEN-1:0]            rd_data_out,
    output logic [NUM_READ-1:0]                 rd_busy_out,
    output logic [NUM_READ*ROB_WIDTH-1:0]       rd_tag_out,
    output logic [RS_WIDTH-1:0]                 rd_index_out
);

    logic [XLEN-1:0]      r_regs [NUM_ARCH_REGS];
    logic                 r_busy [NUM_ARCH_REGS];
    logic [ROB_WIDTH-1:0] r_tag  [NUM_ARCH_REGS];

    logic [XLEN-1:0]      r_rd_data  [NUM_READ];
    logic                 r_rd_busy  [NUM_READ];
    logic [ROB_WIDTH-1:0] r_rd_tag   [NUM_READ];
    logic [NUM_READ-1:0]  r_rd_valid;
    logic [RS_WIDTH-1:0]  r_rd_index;

    logic [XLEN-1:0]      w_data [NUM_READ];
    logic                 w_busy [NUM_READ];
    logic [ROB_WIDTH-1:0] w_tag  [NUM_READ];
    logic [NUM_READ-1:0]  w_accept;
    logic                 w_rn_hit_cm;

    assign w_rn_hit_cm = rn_valid_in && (rn_rd_in == cm_rd_in);
    assign w_accept    = flush_in ? '0 : rd_req_in;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        logic [REG_ADDR_WIDTH-1:0] w_addr;
        assign w_addr = rd_addr_in[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

        reg_file_read_port #(
            .XLEN      (XLEN),
            .ROB_WIDTH (ROB_WIDTH)
        ) u_port (
            .i_addr     (w_addr),
            .i_reg_data (r_regs[w_addr]),
            .i_reg_busy (r_busy[w_addr]),
            .i_reg_tag  (r_tag[w_addr]),
            .i_cm_valid (cm_valid_in),
            .i_cm_rd    (cm_rd_in),
            .i_cm_tag   (cm_tag_in),
            .i_cm_data  (cm_data_in),
            .o_data     (w_data[p]),
            .o_busy     (w_busy[p]),
            .o_tag      (w_tag[p])
        );

        assign rd_data_out[p*XLEN +: XLEN]           = r_rd_data[p];
        assign rd_busy_out[p]                        = r_rd_busy[p];
        assign rd_tag_out[p*ROB_WIDTH +: ROB_WIDTH]  = r_rd_tag[p];
    end

    assign rd_valid_out = r_rd_valid;
    assign rd_index_out = r_rd_index;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_regs[i] <= '0;
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (cm_valid_in && (cm_rd_in != '0)) begin
                r_regs[cm_rd_in] <= cm_data_in;
                if (r_busy[cm_rd_in] && (r_tag[cm_rd_in] == cm_tag_in) && !w_rn_hit_cm) begin
                    r_busy[cm_rd_in] <= 1'b0;
                end
            end
            // Flush discards every in-flight producer, including this cycle's rename.
            if (flush_in) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                    r_busy[i] <= 1'b0;
                end
            end else if (rn_valid_in && (rn_rd_in != '0)) begin
                r_busy[rn_rd_in] <= 1'b1;
                r_tag[rn_rd_in]  <= rn_tag_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_valid <= '0;
            r_rd_index <= '0;
            for (int p = 0; p < NUM_READ; p++) begin
                r_rd_data[p] <= '0;
                r_rd_busy[p] <= 1'b0;
                r_rd_tag[p]  <= '0;
            end
        end else if (rdy_in) begin
            r_rd_valid <= w_accept;
            if (|w_accept) begin
                r_rd_index <= rd_index_in;
            end
            for (int p = 0; p < NUM_READ; p++) begin
                if (w_accept[p]) begin
                    r_rd_data[p] <= w_data[p];
                    r_rd_busy[p] <= w_busy[p];
                    r_rd_tag[p]  <= w_tag[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: rename, commit bypass, stale commits, flush, x0, stall and reset.
module tb_reg_file_rename;
    import reg_file_rename_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic [1:0]  rd_req_in;
    logic [9:0]  rd_addr_in;
    logic [1:0]  rd_index_in;
    logic        rn_valid_in;
    logic [4:0]  rn_rd_in;
    logic [2:0]  rn_tag_in;
    logic        cm_valid_in;
    logic [4:0]  cm_rd_in;
    logic [2:0]  cm_tag_in;
    logic [31:0] cm_data_in;
    logic [1:0]  rd_valid_out;
    logic [63:0] rd_data_out;
    logic [1:0]  rd_busy_out;
    logic [5:0]  rd_tag_out;
    logic [1:0]  rd_index_out;

    int n_checks = 0;
    int n_errors = 0;

    rd_rsp_t exp_q[$];
    int      port_q[$];
    bit      care_q[$];

    reg_file_rename dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .rd_req_in    (rd_req_in),
        .rd_addr_in   (rd_addr_in),
        .rd_index_in  (rd_index_in),
        .rn_valid_in  (rn_valid_in),
        .rn_rd_in     (rn_rd_in),
        .rn_tag_in    (rn_tag_in),
        .cm_valid_in  (cm_valid_in),
        .cm_rd_in     (cm_rd_in),
        .cm_tag_in    (cm_tag_in),
        .cm_data_in   (cm_data_in),
        .rd_valid_out (rd_valid_out),
        .rd_data_out  (rd_data_out),
        .rd_busy_out  (rd_busy_out),
        .rd_tag_out   (rd_tag_out),
        .rd_index_out (rd_index_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rd_req_in   = '0;
        flush_in    = 1'b0;
        rn_valid_in = 1'b0;
        cm_valid_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        clear_inputs();
    endtask

    task automatic do_read(input int p, input logic [4:0] r);
        rd_req_in[p]        = 1'b1;
        rd_addr_in[p*5 +: 5] = r;
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [2:0] t);
        rn_valid_in = 1'b1;
        rn_rd_in    = r;
        rn_tag_in   = t;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [2:0] t, input logic [31:0] d);
        cm_valid_in = 1'b1;
        cm_rd_in    = r;
        cm_tag_in   = t;
        cm_data_in  = d;
    endtask

    task automatic expect_rsp(input int p, input logic v, input logic b, input logic [2:0] t,
                              input logic [31:0] d, input bit tag_care = 1'b1);
        rd_rsp_t e;
        e.valid = v;
        e.busy  = b;
        e.tag   = t;
        e.data  = d;
        exp_q.push_back(e);
        port_q.push_back(p);
        care_q.push_back(tag_care);
    endtask

    task automatic check_rsp(input string tag);
        rd_rsp_t e;
        int      p;
        bit      c;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = port_q.pop_front();
            c = care_q.pop_front();
            check($sformatf("%s_p%0d_valid", tag, p), 64'(rd_valid_out[p]), 64'(e.valid));
            if (e.valid) begin
                check($sformatf("%s_p%0d_busy", tag, p), 64'(rd_busy_out[p]), 64'(e.busy));
                check($sformatf("%s_p%0d_data", tag, p), 64'(rd_data_out[p*32 +: 32]), 64'(e.data));
                if (c) check($sformatf("%s_p%0d_tag", tag, p), 64'(rd_tag_out[p*3 +: 3]), 64'(e.tag));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(rd_valid_out), 64'h0);
        check({tag, "_data"},  rd_data_out,       64'h0);
        check({tag, "_busy"},  64'(rd_busy_out),  64'h0);
        check({tag, "_tag"},   64'(rd_tag_out),   64'h0);
        check({tag, "_index"}, 64'(rd_index_out), 64'h0);
    endtask

    initial begin
        rst_n_in    = 1'b0;
        rdy_in      = 1'b1;
        rd_addr_in  = '0;
        rd_index_in = '0;
        rn_rd_in    = '0;
        rn_tag_in   = '0;
        cm_rd_in    = '0;
        cm_tag_in   = '0;
        cm_data_in  = '0;
        clear_inputs();
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_n_in = 1'b1;

        // Fresh register reads as zero, not busy.
        rd_index_in = 2'd2;
        do_read(0, 5'd5);
        expect_rsp(0, 1, 0, 0, 0);
        expect_rsp(1, 0, 0, 0, 0);
        step();
        check_rsp("rst_rd");
        check("rst_rd_index", 64'(rd_index_out), 64'd2);

        // Rename x3 -> tag 4; a same-cycle read does not see it.
        do_rename(5'd3, 3'd4);
        do_read(1, 5'd3);
        expect_rsp(1, 1, 0, 0, 0);
        step();
        check_rsp("rn_same");

        rd_index_in = 2'd1;
        do_read(0, 5'd3);
        expect_rsp(0, 1, 1, 4, 0);
        step();
        check_rsp("rn_busy");
        check("rn_busy_index", 64'(rd_index_out), 64'd1);

        do_commit(5'd3, 3'd4, 32'hDEADBEEF);
        do_read(0, 5'd3);
        expect_rsp(0, 1, 0, 0, 32'hDEADBEEF, 1'b0);
        step();
        check_rsp("bypass");

        do_read(0, 5'd3);
        expect_rsp(0, 1, 0, 4, 32'hDEADBEEF);
        step();
        check_rsp("cm_clear");

        // Stale commit on x7 writes data but keeps the newer producer.
        do_rename(5'd7, 3'd1);
        step();
        do_rename(5'd7, 3'd2);
        step();
        do_commit(5'd7, 3'd1, 32'h11);
        do_read(0, 5'd7);
        expect_rsp(0, 1, 1, 2, 0);
        step();
        check_rsp("stale_same");

        do_read(0, 5'd7);
        expect_rsp(0, 1, 1, 2, 32'h11);
        step();
        check_rsp("stale");

        do_rename(5'd7, 3'd3);
        do_commit(5'd7, 3'd2, 32'h22);
        do_read(1, 5'd7);
        expect_rsp(1, 1, 0, 0, 32'h22, 1'b0);
        step();
        check_rsp("rn_cm_byp");

        do_read(0, 5'd7);
        expect_rsp(0, 1, 1, 3, 32'h22);
        step();
        check_rsp("rn_wins");

        // Flush: reads dropped, busy cleared, commit kept, rename dropped.
        do_commit(5'd1, 3'd0, 32'hAAAA);
        step();
        do_rename(5'd1, 3'd5);
        step();
        do_rename(5'd2, 3'd6);
        step();
        flush_in = 1'b1;
        do_read(0, 5'd1);
        do_read(1, 5'd2);
        do_commit(5'd4, 3'd0, 32'h44);
        do_rename(5'd9, 3'd7);
        expect_rsp(0, 0, 0, 0, 0);
        expect_rsp(1, 0, 0, 0, 0);
        step();
        check_rsp("flush_rd");

        do_read(0, 5'd1);
        do_read(1, 5'd2);
        expect_rsp(0, 1, 0, 5, 32'hAAAA);
        expect_rsp(1, 1, 0, 6, 0);
        step();
        check_rsp("post_flush");

        do_read(0, 5'd4);
        do_read(1, 5'd9);
        expect_rsp(0, 1, 0, 0, 32'h44);
        expect_rsp(1, 1, 0, 0, 0);
        step();
        check_rsp("flush_cm_rn");

        // x0 ignores commit and rename.
        do_commit(5'd0, 3'd0, 32'hFFFF);
        do_rename(5'd0, 3'd3);
        do_read(0, 5'd0);
        do_read(1, 5'd0);
        expect_rsp(0, 1, 0, 0, 0);
        expect_rsp(1, 1, 0, 0, 0);
        step();
        check_rsp("x0_same");

        do_read(0, 5'd0);
        do_read(1, 5'd0);
        expect_rsp(0, 1, 0, 0, 0);
        expect_rsp(1, 1, 0, 0, 0);
        step();
        check_rsp("x0");

        // Stall: outputs and state frozen while rdy_in is low.
        do_rename(5'd10, 3'd2);
        step();
        rd_index_in = 2'd3;
        do_read(0, 5'd10);
        expect_rsp(0, 1, 1, 2, 0);
        expect_rsp(1, 0, 0, 0, 0);
        step();
        check_rsp("pre_hold");

        for (int i = 0; i < 3; i++) begin
            rdy_in      = 1'b0;
            rd_index_in = 2'd0;
            do_read(1, 5'd3);
            do_commit(5'd10, 3'd2, 32'h55);
            expect_rsp(0, 1, 1, 2, 0);
            expect_rsp(1, 0, 0, 0, 0);
            step();
            check_rsp($sformatf("hold%0d", i));
            check($sformatf("hold%0d_index", i), 64'(rd_index_out), 64'd3);
        end
        rdy_in = 1'b1;

        do_read(0, 5'd10);
        expect_rsp(0, 1, 1, 2, 0);
        step();
        check_rsp("after_hold");

        // Asynchronous reset mid-sequence.
        do_read(0, 5'd3);
        expect_rsp(0, 1, 0, 4, 32'hDEADBEEF);
        step();
        check_rsp("pre_rst");
        #2;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        do_read(0, 5'd3);
        expect_rsp(0, 1, 0, 0, 0);
        step();
        check_rsp("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Parametrised successor to the core register file: 32 x XLEN architectural registers, plus a per-register busy bit and ROB tag (rename table).
- Provides NUM_READ registered read ports toward the reservation station, returning data or a pending ROB tag.
- Takes one rename per cycle from dispatch and one commit per cycle from the ROB, with same-cycle commit bypass and a global flush for branch mispredict.

Parameters:
XLEN, 32, register data width
NUM_READ, 2, number of read ports (1..4)
RS_WIDTH, 2, width of the RS entry index carried with a read
ROB_WIDTH, 3, width of the ROB tag

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; when low, all state and outputs hold
flush_in  input  1  mispredict flush
rd_req_in  input  NUM_READ  per-port read request valid
rd_addr_in  input  NUM_READ*5  per-port source register; port p at [5p+4:5p]
rd_index_in  input  RS_WIDTH  RS entry index shared by all ports of a request
rn_valid_in  input  1  rename request from dispatch
rn_rd_in  input  5  destination register being renamed
rn_tag_in  input  ROB_WIDTH  ROB tag allocated to rn_rd_in
cm_valid_in  input  1  ROB commit
cm_rd_in  input  5  commit destination register
cm_tag_in  input  ROB_WIDTH  ROB tag of the committing entry
cm_data_in  input  XLEN  commit write data
rd_valid_out  output  NUM_READ  per-port response valid
rd_data_out  output  NUM_READ*XLEN  per-port register value
rd_busy_out  output  NUM_READ  per-port operand-pending flag
rd_tag_out  output  NUM_READ*ROB_WIDTH  producing ROB tag when busy
rd_index_out  output  RS_WIDTH  echoed rd_index_in

Behaviour:
- Reset (rst_n_in low, asynchronous): all data, busy bits, tags and outputs are 0. Reset acts regardless of rdy_in.
- rdy_in low: nothing changes, including outputs.
- Read latency is 1 cycle. In the cycle after a request on port p:
  - rd_valid_out[p] = 1.
  - rd_index_out = rd_index_in.
  - Ports without a request give valid 0; their other fields are don't-care but deterministic (hold).
- Read ordering within a cycle is commit-before, rename-after:
  - Reads see the commit of the same cycle.
  - Reads do not see the rename of the same cycle.
- Read result for register r:
  - r = 0: data 0, busy 0, tag 0.
  - If cm_valid_in, cm_rd_in = r, busy[r] = 1 and cm_tag_in = tag[r]: data = cm_data_in, busy 0 (bypass).
  - Otherwise: data = reg[r], busy = busy[r], tag = tag[r].
- Commit (cm_valid_in, cm_rd_in != 0):
  - reg[cm_rd_in] <= cm_data_in unconditionally.
  - busy is cleared only if busy = 1 and the tag matches and there is no same-cycle rename to the same register. A stale (non-matching) commit leaves busy/tag unchanged.
- Rename (rn_valid_in, rn_rd_in != 0): busy[rn_rd_in] <= 1, tag[rn_rd_in] <= rn_tag_in. Rename wins over a same-cycle commit to the same register.
- Writes and renames to x0 are ignored; x0 always reads 0.
- Flush:
  - Clears all busy bits; data and tags are unaffected.
  - A commit in the same cycle still writes data.
  - A rename in the same cycle is ignored.
  - Reads requested in the flush cycle produce rd_valid_out = 0 next cycle.
- Several ports reading the same register return identical results.

Decomposition:
- Shared package: REG_ADDR_WIDTH = 5, NUM_ARCH_REGS = 32, default XLEN, and a read-response struct {valid, busy, tag, data}.
- One natural sub-module, reg_file_read_port: combinational lookup with x0 and commit-bypass logic, instantiated NUM_READ times with registered outputs in the parent.

Test Plan:
- Reset then read x5 on port 0 -> next cycle valid 1, data 0, busy 0.
- Rename x3 -> tag 4; next cycle read x3 -> busy 1, tag 4. Then commit x3/tag 4/0xDEADBEEF while reading x3 -> bypass gives data 0xDEADBEEF, busy 0; busy[3] = 0 afterwards.
- Rename x7 tag 1, then rename x7 tag 2, then commit x7 tag 1 with 0x11 -> reg[7] = 0x11, read shows busy 1, tag 2. Rename x7 tag 3 in the same cycle as commit x7 tag 2 -> busy 1, tag 3.
- Rename x1 and x2, then flush with a read of x1 in the same cycle -> that response has valid 0. A subsequent read of x1 -> busy 0, old data.
- Commit x0 with 0xFFFF and rename x0 -> reads of x0 on all ports return 0, busy 0.
- Hold rdy_in low for 3 cycles during a pending read and commit -> outputs and state frozen; assert rst_n_in low mid-sequence -> all outputs 0 immediately.
